abus_initiator: RTL and testbench
=================================

# abus_initiator

Synthesizable Saturn A-bus cycle initiator: the host-side counterpart of the A-bus/SDRAM bridge. It turns single read/write commands from a valid/ready port into A-bus strobe sequences with programmable setup/strobe/hold lengths, and returns read data. It sits in the bench/loopback build, driving the bridge's A-bus pins directly so that bridge and SDRAM paths can be exercised without a Saturn console.

## Interface

Parameters:
- SETUP_CYCLES, default 2: cycles address/CS are valid before the strobe; legal range 1..255.
- STROBE_CYCLES, default 4: cycles read_n/wbe_n are asserted; legal range 1..255.
- HOLD_CYCLES, default 2: cycles address/CS/write data are held after the strobe; legal range 1..255.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_cs  in  2  chip select index 0..2; value 3 is illegal.
- cmd_addr  in  25  A-bus address.
- cmd_wdata  in  16  write data.
- cmd_be_n  in  2  active-low byte enables for writes ([1] = D15:8).
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  16  captured read data.
- proto_err  out  1  sticky protocol error flag.
- abus_address  out  25  A-bus address.
- abus_chipselect_n  out  3  active-low chip selects (CS0..CS2).
- abus_read_n  out  1  active-low read strobe.
- abus_writebyteenable_n  out  2  active-low write strobes.
- abus_data  inout  16  A-bus data; driven only during write cycles.
- abus_direction  in  1  bridge transceiver direction, 1 = bridge driving data.

## Operation

- FSM states: IDLE, SETUP, STROBE, HOLD, plus TURN when compiled in (see Configuration).
- IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch all cmd_* fields; go to SETUP.
- SETUP: abus_address = latched addr; abus_chipselect_n bit cmd_cs low; write cycles drive abus_data = wdata. Lasts SETUP_CYCLES, then STROBE.
- STROBE: reads assert abus_read_n = 0; writes assert abus_writebyteenable_n = latched be_n. Lasts STROBE_CYCLES. For reads, abus_data is sampled into rsp_rdata on the clock edge that ends the last STROBE cycle. Then HOLD.
- HOLD: strobes deasserted (all 1); address, CS and write data held. rsp_valid = 1 in the first HOLD cycle of read cycles only. After HOLD_CYCLES, go to IDLE.
- Phase counter: 8-bit, loaded with parameter-1 on phase entry, decrements to 0.
- cmd_cs = 3 on accept: no chipselect is asserted, cycle still runs with full timing, proto_err set.
- Read with abus_direction = 0 on the final STROBE cycle: proto_err set; data is still captured and returned.
- Write with be_n = 2'b11: legal; cycle runs, no strobe edge visible.
- proto_err is cleared only by reset.

## Timing

- Reset (reset_n low at an edge) forces next cycle: IDLE, cmd_ready = 1 once reset_n high, rsp_valid = 0, rsp_rdata = 0, proto_err = 0, abus_address = 0, abus_chipselect_n = 3'b111, abus_read_n = 1, abus_writebyteenable_n = 2'b11, abus_data = Z.
- Reset mid-cycle aborts immediately with the above values; no rsp_valid is produced for the aborted read.
- All A-bus outputs are registered; no combinational path from cmd_* to pins.
- Command accepted at edge T: SETUP occupies T+1..T+SETUP_CYCLES; the read rsp_valid pulse arrives SETUP_CYCLES+STROBE_CYCLES+1 cycles after T.
- Total occupancy is 1+SETUP+STROBE+HOLD cycles per command: 9 cycles at defaults. cmd_ready is low throughout.
- abus_data output enable is asserted from first SETUP cycle to last HOLD cycle of writes; never asserted on reads.

## Configuration

- ABUS_INITIATOR_TURNAROUND_EN defined: after a read's HOLD, if the next accepted command is a write, one TURN cycle is inserted before SETUP. TURN has all strobes and CS deasserted and abus_data at Z, which prevents contention with the bridge releasing the bus. Read→read, write→any: no TURN.
- Not defined: no TURN state; a write may begin SETUP the cycle after acceptance, regardless of the previous cycle type.

## Test plan

- Reset with all outputs X-free: after 2 cycles of reset_n=0, all pins equal the reset values listed above; cmd_ready=1 after release.
- Write cs=0, addr=0x0200000, data=0xA55A, be_n=00, default params: CS0 low for 8 cycles, wbe_n=00 for exactly 4 cycles, data=0xA55A for all 8, cmd_ready returns after 9.
- Read cs=1, addr=0x1000000, bridge model drives 0x1234 with direction=1: read_n low 4 cycles; rsp_valid single pulse 7 cycles after accept with rdata=0x1234; proto_err=0.
- Read with direction=0 held: rsp_valid still pulses; proto_err=1 and stays 1 until reset. cmd_cs=3 also sets proto_err with all chipselect_n=1.
- Reset asserted during STROBE of a read: next cycle read_n=1, CS all 1, no rsp_valid ever; next command runs normally.
- With ABUS_INITIATOR_TURNAROUND_EN, back-to-back read then write: exactly one idle cycle with abus_data=Z and CS=111 between the read HOLD and the write SETUP. Without the macro, that cycle is absent.

Source files
------------

// File: rtl/abus_initiator.sv
// rtl/abus_initiator.sv - Saturn A-bus cycle initiator (optional TURN cycle: ABUS_INITIATOR_TURNAROUND_EN)
`timescale 1ns/1ps
module abus_initiator #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_cs,
    input  logic [24:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [1:0]  cmd_be_n,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        proto_err,
    output logic [24:0] abus_address,
    output logic [2:0]  abus_chipselect_n,
    output logic        abus_read_n,
    output logic [1:0]  abus_writebyteenable_n,
    inout  wire  [15:0] abus_data,
    input  logic        abus_direction
);

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        write_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_n_q;
    logic        oe_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic        proto_err_q;
    logic [24:0] abus_address_q;
    logic [2:0]  abus_cs_n_q;
    logic        abus_read_n_q;
    logic [1:0]  abus_wbe_n_q;
`ifdef ABUS_INITIATOR_TURNAROUND_EN
    logic [1:0]  cs_q;
    logic        last_read_q;
`endif

    // cs index 3 is illegal and selects nothing
    function automatic logic [2:0] cs_decode(input logic [1:0] cs);
        logic [2:0] v;
        v = 3'b111;
        if (cs != 2'd3) v[cs] = 1'b0;
        return v;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            write_q        <= 1'b0;
            wdata_q        <= 16'd0;
            be_n_q         <= 2'b11;
            oe_q           <= 1'b0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 16'd0;
            proto_err_q    <= 1'b0;
            abus_address_q <= 25'd0;
            abus_cs_n_q    <= 3'b111;
            abus_read_n_q  <= 1'b1;
            abus_wbe_n_q   <= 2'b11;
`ifdef ABUS_INITIATOR_TURNAROUND_EN
            cs_q           <= 2'd0;
            last_read_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        write_q        <= cmd_write;
                        wdata_q        <= cmd_wdata;
                        be_n_q         <= cmd_be_n;
                        abus_address_q <= cmd_addr;
                        cmd_ready_q    <= 1'b0;
                        if (cmd_cs == 2'd3) proto_err_q <= 1'b1;
`ifdef ABUS_INITIATOR_TURNAROUND_EN
                        cs_q <= cmd_cs;
                        if (cmd_write && last_read_q) begin
                            state_q <= ST_TURN;
                        end else begin
                            state_q     <= ST_SETUP;
                            cnt_q       <= SETUP_LOAD;
                            abus_cs_n_q <= cs_decode(cmd_cs);
                            oe_q        <= cmd_write;
                        end
`else
                        state_q     <= ST_SETUP;
                        cnt_q       <= SETUP_LOAD;
                        abus_cs_n_q <= cs_decode(cmd_cs);
                        oe_q        <= cmd_write;
`endif
                    end
                end
`ifdef ABUS_INITIATOR_TURNAROUND_EN
                // bridge has had one cycle to release the data bus
                ST_TURN: begin
                    state_q     <= ST_SETUP;
                    cnt_q       <= SETUP_LOAD;
                    abus_cs_n_q <= cs_decode(cs_q);
                    oe_q        <= write_q;
                end
`endif
                ST_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= STROBE_LOAD;
                        if (write_q) abus_wbe_n_q  <= be_n_q;
                        else         abus_read_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == 8'd0) begin
                        state_q       <= ST_HOLD;
                        cnt_q         <= HOLD_LOAD;
                        abus_read_n_q <= 1'b1;
                        abus_wbe_n_q  <= 2'b11;
                        if (!write_q) begin
                            rsp_rdata_q <= abus_data;
                            rsp_valid_q <= 1'b1;
                            if (!abus_direction) proto_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_q     <= ST_IDLE;
                        abus_cs_n_q <= 3'b111;
                        oe_q        <= 1'b0;
                        cmd_ready_q <= 1'b1;
`ifdef ABUS_INITIATOR_TURNAROUND_EN
                        last_read_q <= !write_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    abus_cs_n_q <= 3'b111;
                    oe_q        <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready              = cmd_ready_q;
    assign rsp_valid              = rsp_valid_q;
    assign rsp_rdata              = rsp_rdata_q;
    assign proto_err              = proto_err_q;
    assign abus_address           = abus_address_q;
    assign abus_chipselect_n      = abus_cs_n_q;
    assign abus_read_n            = abus_read_n_q;
    assign abus_writebyteenable_n = abus_wbe_n_q;
    assign abus_data              = oe_q ? wdata_q : 16'bz;

endmodule

// File: tb/tb_abus_initiator.sv
// tb/tb_abus_initiator.sv - self-checking bench for abus_initiator
`timescale 1ns/1ps
module tb_abus_initiator;

    localparam int S   = 2;
    localparam int ST  = 4;
    localparam int H   = 2;
    localparam int ACT = S + ST + H;
`ifdef ABUS_INITIATOR_TURNAROUND_EN
    localparam int TURN_EN = 1;
`else
    localparam int TURN_EN = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_cs = 2'd0;
    logic [24:0] cmd_addr = 25'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic [1:0]  cmd_be_n = 2'b11;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        proto_err;
    logic [24:0] abus_address;
    logic [2:0]  abus_chipselect_n;
    logic        abus_read_n;
    logic [1:0]  abus_writebyteenable_n;
    wire  [15:0] abus_data;
    logic        abus_direction = 1'b1;
    logic [15:0] bridge_val = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;
    bit last_read = 1'b0;

    // bridge model: drives the bus while the read strobe is low
    assign abus_data = (!abus_read_n) ? bridge_val : 16'bz;

    always #5 clock = ~clock;

    abus_initiator #(.SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_cs(cmd_cs), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be_n(cmd_be_n),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .proto_err(proto_err),
        .abus_address(abus_address), .abus_chipselect_n(abus_chipselect_n),
        .abus_read_n(abus_read_n), .abus_writebyteenable_n(abus_writebyteenable_n),
        .abus_data(abus_data), .abus_direction(abus_direction)
    );

    typedef struct {
        logic        write;
        logic [1:0]  cs;
        logic [24:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be_n;
        logic [15:0] rdata;
    } cmd_t;

    typedef struct {
        logic       ready;
        logic [2:0] cs_n;
        logic       read_n;
        logic [1:0] wbe_n;
        logic       rsp;
        logic       drive;
    } exp_t;

    // expected pins k cycles after the accept edge, t = inserted turnaround cycles
    function automatic exp_t model(cmd_t c, int k, int t);
        exp_t e;
        int   d;
        bit   act, strobe;
        logic [2:0] one;
        d      = k - t;
        act    = (d >= 1) && (d <= ACT);
        strobe = act && (d > S) && (d <= S + ST);
        one    = 3'b001 << c.cs;
        e.ready  = (d > ACT);
        e.cs_n   = (act && c.cs != 2'd3) ? ~one : 3'b111;
        e.read_n = !(strobe && !c.write);
        e.wbe_n  = (strobe && c.write) ? c.be_n : 2'b11;
        e.rsp    = !c.write && (d == S + ST + 1);
        e.drive  = act && c.write;
        return e;
    endfunction

    task automatic issue(input cmd_t c, output int t);
        t          = (TURN_EN != 0 && c.write && last_read) ? 1 : 0;
        last_read  = !c.write;
        cmd_write  = c.write;
        cmd_cs     = c.cs;
        cmd_addr   = c.addr;
        cmd_wdata  = c.wdata;
        cmd_be_n   = c.be_n;
        bridge_val = c.rdata;
        cmd_valid  = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        last_read = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 16'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        n_checks++; if (abus_address !== 25'd0) begin n_fail++; $display("FAIL reset_address got %h want 0", abus_address); end
        n_checks++; if (abus_chipselect_n !== 3'b111) begin n_fail++; $display("FAIL reset_cs_n got %b want 111", abus_chipselect_n); end
        n_checks++; if (abus_read_n !== 1'b1) begin n_fail++; $display("FAIL reset_read_n got %b want 1", abus_read_n); end
        n_checks++; if (abus_writebyteenable_n !== 2'b11) begin n_fail++; $display("FAIL reset_wbe_n got %b want 11", abus_writebyteenable_n); end
        reset_n   = 1'b1;
        last_read = 1'b0;
        @(posedge clock);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        cmd_t c;
        exp_t e;
        int   t;
        int   cs_cnt = 0, wbe_cnt = 0;
        c = '{write: 1'b1, cs: 2'd0, addr: 25'h0200000, wdata: 16'hA55A, be_n: 2'b00, rdata: 16'h0};
        issue(c, t);
        for (int k = 1; k <= ACT + 1; k++) begin
            e = model(c, k, t);
            if (abus_chipselect_n == 3'b110) cs_cnt++;
            if (abus_writebyteenable_n == 2'b00) wbe_cnt++;
            n_checks++; if (abus_chipselect_n !== e.cs_n) begin n_fail++; $display("FAIL wr_cs_n k=%0d got %b want %b", k, abus_chipselect_n, e.cs_n); end
            n_checks++; if (abus_writebyteenable_n !== e.wbe_n) begin n_fail++; $display("FAIL wr_wbe_n k=%0d got %b want %b", k, abus_writebyteenable_n, e.wbe_n); end
            n_checks++; if (abus_read_n !== 1'b1) begin n_fail++; $display("FAIL wr_read_n k=%0d got %b want 1", k, abus_read_n); end
            n_checks++; if (cmd_ready !== e.ready) begin n_fail++; $display("FAIL wr_ready k=%0d got %b want %b", k, cmd_ready, e.ready); end
            if (e.drive) begin
                n_checks++; if (abus_data !== c.wdata) begin n_fail++; $display("FAIL wr_data k=%0d got %h want %h", k, abus_data, c.wdata); end
                n_checks++; if (abus_address !== c.addr) begin n_fail++; $display("FAIL wr_addr k=%0d got %h want %h", k, abus_address, c.addr); end
            end
            if (k <= ACT) begin @(posedge clock); #1; end
        end
        n_checks++; if (cs_cnt != ACT) begin n_fail++; $display("FAIL wr_cs_cycles got %0d want %0d", cs_cnt, ACT); end
        n_checks++; if (wbe_cnt != ST) begin n_fail++; $display("FAIL wr_wbe_cycles got %0d want %0d", wbe_cnt, ST); end
    endtask

    task automatic test_read();
        cmd_t c;
        exp_t e;
        int   t;
        int   pulses = 0;
        c = '{write: 1'b0, cs: 2'd1, addr: 25'h1000000, wdata: 16'h0, be_n: 2'b11, rdata: 16'h1234};
        abus_direction = 1'b1;
        issue(c, t);
        for (int k = 1; k <= ACT + 1; k++) begin
            e = model(c, k, t);
            if (rsp_valid) pulses++;
            n_checks++; if (abus_chipselect_n !== e.cs_n) begin n_fail++; $display("FAIL rd_cs_n k=%0d got %b want %b", k, abus_chipselect_n, e.cs_n); end
            n_checks++; if (abus_read_n !== e.read_n) begin n_fail++; $display("FAIL rd_read_n k=%0d got %b want %b", k, abus_read_n, e.read_n); end
            n_checks++; if (rsp_valid !== e.rsp) begin n_fail++; $display("FAIL rd_rsp_valid k=%0d got %b want %b", k, rsp_valid, e.rsp); end
            if (e.rsp) begin
                n_checks++; if (rsp_rdata !== c.rdata) begin n_fail++; $display("FAIL rd_rdata got %h want %h", rsp_rdata, c.rdata); end
            end
            if (k <= ACT) begin @(posedge clock); #1; end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL rd_pulse_count got %0d want 1", pulses); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rd_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_random();
        cmd_t c;
        exp_t e;
        int   t;
        abus_direction = 1'b1;
        for (int n = 0; n < 24; n++) begin
            c.write = 1'($urandom_range(1));
            c.cs    = 2'($urandom_range(2));
            c.addr  = 25'($urandom);
            c.wdata = 16'($urandom);
            c.be_n  = 2'($urandom_range(3));
            c.rdata = 16'($urandom);
            issue(c, t);
            for (int k = 1; k <= ACT + t + 1; k++) begin
                e = model(c, k, t);
                n_checks++; if (abus_chipselect_n !== e.cs_n) begin n_fail++; $display("FAIL rnd_cs_n n=%0d k=%0d got %b want %b", n, k, abus_chipselect_n, e.cs_n); end
                n_checks++; if (abus_read_n !== e.read_n) begin n_fail++; $display("FAIL rnd_read_n n=%0d k=%0d got %b want %b", n, k, abus_read_n, e.read_n); end
                n_checks++; if (abus_writebyteenable_n !== e.wbe_n) begin n_fail++; $display("FAIL rnd_wbe_n n=%0d k=%0d got %b want %b", n, k, abus_writebyteenable_n, e.wbe_n); end
                n_checks++; if (rsp_valid !== e.rsp) begin n_fail++; $display("FAIL rnd_rsp n=%0d k=%0d got %b want %b", n, k, rsp_valid, e.rsp); end
                n_checks++; if (cmd_ready !== e.ready) begin n_fail++; $display("FAIL rnd_ready n=%0d k=%0d got %b want %b", n, k, cmd_ready, e.ready); end
                if (e.rsp) begin
                    n_checks++; if (rsp_rdata !== c.rdata) begin n_fail++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, rsp_rdata, c.rdata); end
                end
                if (e.drive) begin
                    n_checks++; if (abus_data !== c.wdata) begin n_fail++; $display("FAIL rnd_wdata n=%0d k=%0d got %h want %h", n, k, abus_data, c.wdata); end
                end
                if (k <= ACT + t) begin @(posedge clock); #1; end
            end
        end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rnd_proto_err got %b want 0", proto_err); end
    endtask

    task automatic test_back_to_back();
        cmd_t r, w;
        int   t, gap;
        r = '{write: 1'b0, cs: 2'd2, addr: 25'h0001234, wdata: 16'h0, be_n: 2'b11, rdata: 16'h5A5A};
        w = '{write: 1'b1, cs: 2'd2, addr: 25'h0001236, wdata: 16'hC3C3, be_n: 2'b01, rdata: 16'h0};
        issue(r, t);
        for (int k = 1; k <= ACT; k++) begin @(posedge clock); #1; end
        issue(w, t);
        gap = 0;
        for (int k = 1; k <= 6 && abus_chipselect_n == 3'b111; k++) begin
            n_checks++; if (abus_read_n !== 1'b1 || abus_writebyteenable_n !== 2'b11) begin n_fail++; $display("FAIL b2b_idle_strobes k=%0d got %b/%b want 1/11", k, abus_read_n, abus_writebyteenable_n); end
            gap++;
            @(posedge clock); #1;
        end
        n_checks++; if (gap != TURN_EN) begin n_fail++; $display("FAIL b2b_turn_cycles got %0d want %0d", gap, TURN_EN); end
        n_checks++; if (abus_chipselect_n !== 3'b011 || abus_data !== w.wdata) begin n_fail++; $display("FAIL b2b_setup got cs=%b data=%h want 011/%h", abus_chipselect_n, abus_data, w.wdata); end
        for (int k = 1; k <= ACT; k++) begin @(posedge clock); #1; end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_end got %b want 1", cmd_ready); end
    endtask

    task automatic test_reset_abort();
        cmd_t c;
        exp_t e;
        int   t;
        int   pulses = 0;
        c = '{write: 1'b0, cs: 2'd0, addr: 25'h0000040, wdata: 16'h0, be_n: 2'b11, rdata: 16'hBEEF};
        issue(c, t);
        for (int k = 1; k < S + 2; k++) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        n_checks++; if (abus_read_n !== 1'b1) begin n_fail++; $display("FAIL abort_read_n got %b want 1", abus_read_n); end
        n_checks++; if (abus_chipselect_n !== 3'b111) begin n_fail++; $display("FAIL abort_cs_n got %b want 111", abus_chipselect_n); end
        reset_n   = 1'b1;
        last_read = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid) pulses++;
            @(posedge clock); #1;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_rsp_valid got %0d pulses want 0", pulses); end
        c.rdata = 16'h0F0F;
        issue(c, t);
        for (int k = 1; k <= ACT + 1; k++) begin
            e = model(c, k, t);
            n_checks++; if (rsp_valid !== e.rsp) begin n_fail++; $display("FAIL abort_next_rsp k=%0d got %b want %b", k, rsp_valid, e.rsp); end
            if (e.rsp) begin
                n_checks++; if (rsp_rdata !== c.rdata) begin n_fail++; $display("FAIL abort_next_rdata got %h want %h", rsp_rdata, c.rdata); end
            end
            if (k <= ACT) begin @(posedge clock); #1; end
        end
    endtask

    task automatic test_proto_err();
        cmd_t c;
        int   t;
        int   pulses = 0;
        c = '{write: 1'b0, cs: 2'd1, addr: 25'h0000100, wdata: 16'h0, be_n: 2'b11, rdata: 16'h7E57};
        abus_direction = 1'b0;
        issue(c, t);
        for (int k = 1; k <= ACT + 1; k++) begin
            if (rsp_valid) begin
                pulses++;
                n_checks++; if (rsp_rdata !== c.rdata) begin n_fail++; $display("FAIL dir_rdata got %h want %h", rsp_rdata, c.rdata); end
            end
            if (k <= ACT) begin @(posedge clock); #1; end
        end
        abus_direction = 1'b1;
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL dir_rsp_pulses got %0d want 1", pulses); end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL dir_proto_err got %b want 1", proto_err); end
        for (int k = 0; k < 5; k++) begin @(posedge clock); #1; end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL dir_proto_sticky got %b want 1", proto_err); end
        do_reset();
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL dir_proto_clear got %b want 0", proto_err); end
        c = '{write: 1'b1, cs: 2'd3, addr: 25'h0000200, wdata: 16'h1111, be_n: 2'b00, rdata: 16'h0};
        issue(c, t);
        for (int k = 1; k <= ACT + 1; k++) begin
            n_checks++; if (abus_chipselect_n !== 3'b111) begin n_fail++; $display("FAIL cs3_cs_n k=%0d got %b want 111", k, abus_chipselect_n); end
            if (k <= ACT) begin @(posedge clock); #1; end
        end
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL cs3_proto_err got %b want 1", proto_err); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cs3_ready got %b want 1", cmd_ready); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_proto_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
